// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, fixed DATA_W-cycle latency, single-cycle result strobe.
`timescale 1ns/1ps
module muldiv_unit #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_W-1:0]     src1,
   input  logic [DATA_W-1:0]     src2,
   input  logic [REG_ADDR_W-1:0] dest_in,
   output logic                  busy,
   output logic                  result_valid,
   output logic [DATA_W-1:0]     result,
   output logic [REG_ADDR_W-1:0] dest_out
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]            state_q,    state_d;
   logic [CNT_W-1:0]      cnt_q,      cnt_d;
   logic                  sel_hi_q,   sel_hi_d;
   logic [DATA_W-1:0]     opnd_q,     opnd_d;
   logic [2*DATA_W-1:0]   prod_q,     prod_d;
   logic [REG_ADDR_W-1:0] dest_q,     dest_d;
   logic                  busy_q,     busy_d;
   logic                  valid_q,    valid_d;
   logic [DATA_W-1:0]     result_q,   result_d;
   logic [REG_ADDR_W-1:0] dest_out_q, dest_out_d;

   logic [DATA_W:0]       mul_sum_s;
   logic [2*DATA_W-1:0]   mul_step_s;
   logic [DATA_W:0]       part_s;
   logic [DATA_W:0]       diff_s;
   logic                  ge_s;
   logic [2*DATA_W-1:0]   div_step_s;
   logic [2*DATA_W-1:0]   step_s;
   logic                  last_s;

   // prod_q is {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV,
   // so the high half is always the MULHU/REMU word and the low half the MUL/DIVU word.
   always_comb begin
      mul_sum_s  = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + {1'b0, opnd_q};
      mul_step_s = prod_q[0] ? {mul_sum_s, prod_q[DATA_W-1:1]}
                             : {1'b0, prod_q[2*DATA_W-1:1]};
      part_s     = {prod_q[2*DATA_W-1:DATA_W], prod_q[DATA_W-1]};
      diff_s     = part_s - {1'b0, opnd_q};
      ge_s       = (part_s >= {1'b0, opnd_q});
      div_step_s = ge_s ? {diff_s[DATA_W-1:0], prod_q[DATA_W-2:0], 1'b1}
                        : {part_s[DATA_W-1:0], prod_q[DATA_W-2:0], 1'b0};
      step_s     = (state_q == S_DIV) ? div_step_s : mul_step_s;
      last_s     = (cnt_q == CNT_W'(DATA_W - 1));
   end

   // Next-state logic: accept in IDLE/DONE, iterate in MUL/DIV, publish on the last step.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sel_hi_d   = sel_hi_q;
      opnd_d     = opnd_q;
      prod_d     = prod_q;
      dest_d     = dest_q;
      busy_d     = busy_q;
      valid_d    = 1'b0;
      result_d   = result_q;
      dest_out_d = dest_out_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d  = op[1] ? S_DIV : S_MUL;
               cnt_d    = {CNT_W{1'b0}};
               sel_hi_d = op[0];
               opnd_d   = op[1] ? src2 : src1;
               prod_d   = {{DATA_W{1'b0}}, (op[1] ? src1 : src2)};
               dest_d   = dest_in;
               busy_d   = 1'b1;
            end else begin
               state_d  = S_IDLE;
               busy_d   = 1'b0;
            end
         end
         S_MUL, S_DIV: begin
            prod_d = step_s;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last_s) begin
               state_d    = S_DONE;
               busy_d     = 1'b0;
               valid_d    = 1'b1;
               result_d   = sel_hi_q ? step_s[2*DATA_W-1:DATA_W] : step_s[DATA_W-1:0];
               dest_out_d = dest_q;
            end else begin
               state_d    = state_q;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         sel_hi_q   <= 1'b0;
         opnd_q     <= {DATA_W{1'b0}};
         prod_q     <= {(2*DATA_W){1'b0}};
         dest_q     <= {REG_ADDR_W{1'b0}};
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         result_q   <= {DATA_W{1'b0}};
         dest_out_q <= {REG_ADDR_W{1'b0}};
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_hi_q   <= sel_hi_d;
         opnd_q     <= opnd_d;
         prod_q     <= prod_d;
         dest_q     <= dest_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         result_q   <= result_d;
         dest_out_q <= dest_out_d;
      end
   end

   assign busy         = busy_q;
   assign result_valid = valid_q;
   assign result       = result_q;
   assign dest_out     = dest_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected results queued at issue, checked at each strobe.
`timescale 1ns/1ps
module tb_muldiv_unit;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  dst;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] src1 = 32'd0;
   logic [31:0] src2 = 32'd0;
   logic [4:0]  dest_in = 5'd0;
   logic        busy;
   logic        result_valid;
   logic [31:0] result;
   logic [4:0]  dest_out;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   pulses   = 0;
   exp_t sb[$];

   muldiv_unit #(.DATA_W(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
      .dest_in(dest_in), .busy(busy), .result_valid(result_valid),
      .result(result), .dest_out(dest_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (result_valid) pulses <= pulses + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      case (o)
         2'b00:   return p[31:0];
         2'b01:   return p[63:32];
         2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_result"}, result, e.res);
         chk({tag, "_dest"}, {27'd0, dest_out}, {27'd0, e.dst});
      end else begin
         chk({tag, "_no_expectation"}, 32'd0, 32'd1);
      end
   endtask

   // Called on the negedge of cycle k+1 (k = accepting edge); returns cycle offset of the pulse.
   task automatic wait_valid(input int inject_at, output int n, output int busy_n, output logic got);
      n = 1; busy_n = 0; got = 1'b0;
      while (n <= 40 && !got) begin
         if (result_valid) begin
            got = 1'b1;
         end else begin
            if (busy) busy_n++;
            if (n == inject_at) begin
               start = 1'b1; op = 2'b10; src1 = 32'd9; src2 = 32'd3; dest_in = 5'd2;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            n++;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d, input int inject_at);
      exp_t e;
      int n, busy_n;
      logic got;
      e.res = model(o, a, b);
      e.dst = d;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b1; op = o; src1 = a; src2 = b; dest_in = d;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; op = ~o; src1 = $urandom; src2 = $urandom; dest_in = ~d;
      wait_valid(inject_at, n, busy_n, got);
      chk({tag, "_got_pulse"}, 32'(got), 32'd1);
      chk({tag, "_latency"}, 32'(n), 32'd33);
      chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd32);
      chk({tag, "_busy_in_pulse"}, 32'(busy), 32'd0);
      pop_check(tag);
      @(negedge clk);
      chk({tag, "_pulse_one_cycle"}, 32'(result_valid), 32'd0);
      chk({tag, "_result_hold"}, result, e.res);
   endtask

   initial begin
      int   p0, n, busy_n;
      logic got;
      exp_t e;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_valid", 32'(result_valid), 32'd0);
      chk("reset_result", result, 32'd0);
      chk("reset_dest", {27'd0, dest_out}, 32'd0);

      run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 5'd3, 0);
      run_op("mulhu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 0);
      run_op("mul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 0);
      run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 5'd12, 0);
      run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd13, 0);
      run_op("divu_by0", 2'b10, 32'h0000_1234, 32'd0, 5'd14, 0);
      run_op("remu_by0", 2'b11, 32'h0000_1234, 32'd0, 5'd15, 0);
      run_op("mulhu_mix", 2'b01, 32'h8000_0001, 32'h0001_0003, 5'd16, 0);
      run_op("divu_big", 2'b10, 32'hFFFF_FFFE, 32'h8000_0001, 5'd31, 0);

      // Start while busy must be ignored.
      p0 = pulses;
      run_op("ignored_start", 2'b00, 32'd3, 32'd5, 5'd1, 10);
      repeat (40) @(negedge clk);
      chk("ignored_start_no_second_pulse", 32'(pulses), 32'(p0 + 1));

      // Reset mid-divide aborts silently.
      @(negedge clk);
      start = 1'b1; op = 2'b10; src1 = 32'd50; src2 = 32'd5; dest_in = 5'd4;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      p0 = pulses;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(result_valid), 32'd0);
      chk("abort_result", result, 32'd0);
      chk("abort_dest", {27'd0, dest_out}, 32'd0);
      repeat (40) @(negedge clk);
      chk("abort_no_pulse", 32'(pulses), 32'(p0));
      run_op("after_reset_divu", 2'b10, 32'd50, 32'd5, 5'd4, 0);

      // Back-to-back with start held high: second op accepted in the DONE cycle.
      @(negedge clk);
      start = 1'b1; op = 2'b00; src1 = 32'd2; src2 = 32'd2; dest_in = 5'd5;
      e.res = 32'd4; e.dst = 5'd5; sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      src1 = 32'd3; src2 = 32'd3; dest_in = 5'd6;
      e.res = 32'd9; e.dst = 5'd6; sb.push_back(e);
      n = 1; got = 1'b0;
      while (n <= 40 && !got) begin
         if (result_valid) got = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      chk("b2b_first_pulse", 32'(got), 32'd1);
      chk("b2b_first_latency", 32'(n), 32'd33);
      pop_check("b2b_first");
      @(negedge clk);
      start = 1'b0;
      chk("b2b_second_accepted_busy", 32'(busy), 32'd1);
      wait_valid(0, n, busy_n, got);
      chk("b2b_second_pulse", 32'(got), 32'd1);
      chk("b2b_second_latency", 32'(n), 32'd33);
      pop_check("b2b_second");
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
